// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster-timing constants: default 640x480@60 timing, coordinate
//   width (also used by the clock-digit overlay renderer) and small helpers
//   for deriving line/frame totals and sync pin levels.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    // 640x480@60 from a 50 MHz system clock (25 MHz pixels).
    localparam int   DEF_CLK_DIV  = 2;
    localparam int   DEF_H_ACT    = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACT    = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    function automatic int axis_total(input int act, input int fp,
                                      input int sync_w, input int bp);
        return act + fp + sync_w + bp;
    endfunction

    // Pin level for a sync output: the asserted level is pol, idle is ~pol.
    function automatic logic sync_level(input logic on, input logic pol);
        return on ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal pixels or vertical lines). Counts 0..TOTAL-1
//   on each step and reports where the count sits inside the axis timing.
//
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear back to 0 (dominates step)
//   step     in   advance by one position
//   cnt      out  current position, 0..TOTAL-1
//   wrap     out  step taken while at TOTAL-1 (combinational)
//   sync_on  out  cnt inside [SYNC_START, SYNC_START+SYNC_LEN-1]
//   act_on   out  cnt < ACT
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int ACT        = 640
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               sync_on,
    output logic               act_on
);

    localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SYNC_HI = COORD_W'(SYNC_START + SYNC_LEN - 1);
    localparam logic [COORD_W-1:0] ACT_LIM = COORD_W'(ACT);

    logic at_last;

    assign at_last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= at_last ? '0 : cnt + COORD_W'(1);
        end
    end

    assign wrap    = step && at_last;
    assign sync_on = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);
    assign act_on  = (cnt < ACT_LIM);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator. A fixed integer divider turns the system
//   clock into a pixel tick; two axis counters track column and line. Every
//   output is taken from one register stage fed by the same counter state,
//   so coordinates, syncs and active always describe the same pixel and lag
//   the counters by one clk.
//
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low holds everything in the reset state
//   h_sinc       out  horizontal sync (level SYNC_POL while asserted)
//   v_sinc       out  vertical sync (level SYNC_POL while asserted)
//   active       out  pixel inside the visible area
//   px_x, px_y   out  current column / line
//   pix_tick     out  one-clk strobe per pixel period (last clk of the pixel)
//   line_start   out  pix_tick of column 0
//   frame_start  out  pix_tick of column 0, line 0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACT    = DEF_H_ACT,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACT    = DEF_V_ACT,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               h_sinc,
    output logic               v_sinc,
    output logic               active,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOT = axis_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACT, V_FP, V_SYNC, V_BP);

    // Keep the divider at least one bit wide so CLK_DIV==1 still elaborates;
    // in that case div_cnt stays at 0 and tick follows en.
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;

    logic [COORD_W-1:0] h_cnt;
    logic               h_wrap;
    logic               h_sync_on;
    logic               h_act_on;

    logic [COORD_W-1:0] v_cnt;
    logic               v_wrap;
    logic               v_sync_on;
    logic               v_act_on;

    // Set while the next tick is pixel (0,0): after reset/disable and after
    // the last pixel of a frame.
    logic               frame_head;

    assign tick = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_ACT + H_FP),
        .SYNC_LEN   (H_SYNC),
        .ACT        (H_ACT)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!en),
        .step    (tick),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .sync_on (h_sync_on),
        .act_on  (h_act_on)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_ACT + V_FP),
        .SYNC_LEN   (V_SYNC),
        .ACT        (V_ACT)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!en),
        .step    (h_wrap),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .sync_on (v_sync_on),
        .act_on  (v_act_on)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_head <= 1'b1;
        end else if (!en || v_wrap) begin
            frame_head <= 1'b1;
        end else if (tick) begin
            frame_head <= 1'b0;
        end
    end

    // Output stage: sampled from the pre-increment counter state, so every
    // field refers to the pixel the counters hold during this clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sinc      <= ~SYNC_POL;
            v_sinc      <= ~SYNC_POL;
            active      <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            h_sinc      <= ~SYNC_POL;
            v_sinc      <= ~SYNC_POL;
            active      <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sinc      <= sync_level(h_sync_on, SYNC_POL);
            v_sinc      <= sync_level(v_sync_on, SYNC_POL);
            active      <= h_act_on && v_act_on;
            px_x        <= h_cnt;
            px_y        <= v_cnt;
            pix_tick    <= tick;
            line_start  <= tick && (h_cnt == '0);
            frame_start <= tick && frame_head;
        end
    end

endmodule
